// File: rtl/sim_ctrl_dev.sv
// -----------------------------------------------------------------------------
// sim_ctrl_dev -- simulation-control MMIO peripheral.
//
// Sits beside data memory after the core's MEM stage and decodes a 64-byte
// window (8 doublewords) at BASE_ADDR:
//   idx 0 TOHOST   (W)  bit0=1 ends the test, exit code = wdata[32:1]
//   idx 1 CYCLE    (R)  64-bit cycle counter, counts while running
//   idx 2 INSTRET  (R)  64-bit retire counter (only with SIM_CTRL_INSTRET_EN)
//   idx 3 CONSOLE  (W)  push wdata[7:0]; reads {62'b0, overflow, full}
//   idx 4 WD_LIMIT (RW) watchdog limit [31:0], byte-masked, 0 = disabled
//   idx 5-7            reserved, read 0
// Misaligned accesses (mem_addr[2:0] != 0) are ignored and read 0.
//
// Optional feature: define SIM_CTRL_INSTRET_EN to build the INSTRET counter.
// Without it index 2 reads 0 and retire only feeds the watchdog.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   mem_we/mem_re   store/load valid in the MEM stage
//   mem_addr        byte address
//   mem_wdata/mem_be store data and byte enables
//   retire          one instruction retired this cycle
//   hit             address falls in the window (select rdata over dmem)
//   rdata           combinational load data (valid while hit && mem_re)
//   con_valid/con_data/con_ready  console byte stream (ready/valid)
//   done/pass/exit_code           sticky test result
// -----------------------------------------------------------------------------
module sim_ctrl_dev #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] WD_RESET   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_be,
  input  logic        retire,
  output logic        hit,
  output logic [63:0] rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        done,
  output logic        pass,
  output logic [31:0] exit_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [63:0]  cycle_q, cycle_d;
  logic [31:0]  wd_cnt_q, wd_cnt_d;
  logic [31:0]  wd_limit_q, wd_limit_d;
  logic         pass_q, pass_d;
  logic [31:0]  exit_code_q, exit_code_d;
  logic [7:0]   fifo_q [FIFO_DEPTH];
  logic [7:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
`ifdef SIM_CTRL_INSTRET_EN
  logic [63:0]  instret_q, instret_d;
`endif

  // Decode
  logic       aligned;
  logic [2:0] idx;
  logic       wr_ok;
  logic       run;
  logic       tohost_wr;
  logic       con_wr;
  logic       wdl_wr;
  logic       wd_en;
  logic       wd_fire;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // Store data above bit 32 and byte enables 7:4 have no destination.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_wdata[63:33], mem_be[7:4]};

  assign hit     = (mem_addr[63:6] == BASE_ADDR[63:6]);
  assign aligned = (mem_addr[2:0] == 3'd0);
  assign idx     = mem_addr[5:3];
  assign wr_ok   = mem_we && hit && aligned;
  assign run     = (state_q == ST_RUN);

  // Only a store with bit 0 set counts as a TOHOST report; in DONE it is moot.
  assign tohost_wr = wr_ok && (idx == 3'd0) && mem_be[0] && mem_wdata[0] && run;
  assign con_wr    = wr_ok && (idx == 3'd3) && mem_be[0];
  assign wdl_wr    = wr_ok && (idx == 3'd4) && run;

  assign wd_en   = run && (wd_limit_q != 32'd0);
  assign wd_fire = wd_en && !retire && (wd_cnt_q == (wd_limit_q - 32'd1));

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && con_ready;
  // A pop in the same cycle frees the slot, so push-while-full is accepted.
  assign push       = con_wr && (!fifo_full || pop);

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_q[rd_ptr_q];
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign exit_code = exit_code_q;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (run && (tohost_wr || wd_fire)) begin
      state_d = ST_DONE;
    end
  end

  // FSM: outputs -- result latch and run-gated counters
  always_comb begin
    pass_d      = pass_q;
    exit_code_d = exit_code_q;
    cycle_d     = cycle_q;
    wd_cnt_d    = wd_cnt_q;
    wd_limit_d  = wd_limit_q;
`ifdef SIM_CTRL_INSTRET_EN
    instret_d   = instret_q;
`endif

    // TOHOST wins over a watchdog expiry in the same cycle.
    if (tohost_wr) begin
      exit_code_d = mem_wdata[32:1];
      pass_d      = (mem_wdata[32:1] == 32'd0);
    end else if (wd_fire) begin
      exit_code_d = 32'hFFFF_FFFF;
      pass_d      = 1'b0;
    end

    if (run) begin
      cycle_d = cycle_q + 64'd1;
`ifdef SIM_CTRL_INSTRET_EN
      if (retire) begin
        instret_d = instret_q + 64'd1;
      end
`endif
    end

    if (wdl_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          wd_limit_d[8*i +: 8] = mem_wdata[8*i +: 8];
        end
      end
      wd_cnt_d = 32'd0;
    end else if (wd_en) begin
      wd_cnt_d = retire ? 32'd0 : (wd_cnt_q + 32'd1);
    end
  end

  // Console FIFO next state
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (push) begin
      fifo_d[wr_ptr_q] = mem_wdata[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (con_wr && !push) begin
      ovf_d = 1'b1;
    end
  end

  // Control / counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q      <= 1'b0;
      exit_code_q <= 32'd0;
      cycle_q     <= 64'd0;
      wd_cnt_q    <= 32'd0;
      wd_limit_q  <= WD_RESET;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
`ifdef SIM_CTRL_INSTRET_EN
      instret_q   <= 64'd0;
`endif
    end else begin
      pass_q      <= pass_d;
      exit_code_q <= exit_code_d;
      cycle_q     <= cycle_d;
      wd_cnt_q    <= wd_cnt_d;
      wd_limit_q  <= wd_limit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
`ifdef SIM_CTRL_INSTRET_EN
      instret_q   <= instret_d;
`endif
    end
  end

  // FIFO storage is pure data; emptiness is tracked by cnt_q.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Load data mux (pre-edge state)
  always_comb begin
    rdata = 64'd0;
    if (hit && mem_re && aligned) begin
      case (idx)
        3'd1:    rdata = cycle_q;
`ifdef SIM_CTRL_INSTRET_EN
        3'd2:    rdata = instret_q;
`endif
        3'd3:    rdata = {62'd0, ovf_q, fifo_full};
        3'd4:    rdata = {32'd0, wd_limit_q};
        default: rdata = 64'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ctrl_dev.sv
module tb_sim_ctrl_dev;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        retire;
  logic        hit;
  logic [63:0] rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        done;
  logic        pass;
  logic [31:0] exit_code;
  logic        chk_stat;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t con_q[$];
  exp_t st_q[$];
  exp_t e_rd, e_con, e_st;

  sim_ctrl_dev dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .retire    (retire),
    .hit       (hit),
    .rdata     (rdata),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .done      (done),
    .pass      (pass),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whenever the DUT presents a response.
  always @(negedge clk) begin
    if (mem_re && hit) begin
      if (rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_unexpected: got %h expected <none>", rdata);
      end else begin
        e_rd = rd_q.pop_front();
        check(e_rd.name, rdata, e_rd.exp);
      end
    end
    if (con_valid && con_ready) begin
      if (con_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL con_unexpected: got %h expected <none>", con_data);
      end else begin
        e_con = con_q.pop_front();
        check(e_con.name, {56'd0, con_data}, e_con.exp);
      end
    end
    if (chk_stat) begin
      if (st_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL stat_unexpected: got %b/%b/%h expected <none>", done, pass, exit_code);
      end else begin
        e_st = st_q.pop_front();
        check(e_st.name, {30'd0, done, pass, exit_code}, e_st.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input int i, input logic [63:0] d, input logic [7:0] be);
    mem_we    = 1'b1;
    mem_addr  = BASE + 64'(i) * 64'd8;
    mem_wdata = d;
    mem_be    = be;
    tick();
    mem_we    = 1'b0;
    mem_be    = 8'h00;
  endtask

  task automatic ld(input logic [63:0] a, input logic [63:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    rd_q.push_back(e);
    mem_re   = 1'b1;
    mem_addr = a;
    tick();
    mem_re   = 1'b0;
  endtask

  task automatic stat(input logic d, input logic p, input logic [31:0] code, input string name);
    exp_t e;
    e.exp  = {30'd0, d, p, code};
    e.name = name;
    st_q.push_back(e);
    chk_stat = 1'b1;
    tick();
    chk_stat = 1'b0;
  endtask

  task automatic exp_con(input logic [7:0] b, input string name);
    exp_t e;
    e.exp  = {56'd0, b};
    e.name = name;
    con_q.push_back(e);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset_async(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_rst_done"},      {63'd0, done},      64'd0);
    check({tag, "_rst_pass"},      {63'd0, pass},      64'd0);
    check({tag, "_rst_exit"},      {32'd0, exit_code}, 64'd0);
    check({tag, "_rst_con_valid"}, {63'd0, con_valid}, 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0; mem_addr = 64'd0;
    mem_wdata = 64'd0; mem_be = 8'h00; retire = 1'b0; con_ready = 1'b0;
    chk_stat = 1'b0;
    tick();
    stat(1'b0, 1'b0, 32'd0, "init_stat");
    rst = 1'b0;

    // Pass path and CYCLE freeze
    ld(BASE + 64'd8, 64'd0, "cycle_start");
    repeat (19) tick();
    st(0, 64'h1, 8'hFF);
    stat(1'b1, 1'b1, 32'd0, "pass_stat");
    ld(BASE + 64'd8, 64'd21, "cycle_at_done");
    repeat (5) tick();
    ld(BASE + 64'd8, 64'd21, "cycle_frozen");

    // Reset mid-operation: console still accepts pushes in DONE
    st(3, 64'h61, 8'h01);
    st(3, 64'h62, 8'h01);
    check("mid_con_valid", {63'd0, con_valid}, 64'd1);
    check("mid_con_data", {56'd0, con_data}, 64'h61);
    do_reset_async("mid");
    ld(BASE + 64'd8, 64'd0, "cycle_restart");
    ld(BASE + 64'd24, 64'd0, "con_status_after_rst");

    // Fail path
    st(0, 64'h14, 8'hFF);
    stat(1'b0, 1'b0, 32'd0, "tohost_bit0_clear");
    st(0, 64'h15, 8'hFF);
    stat(1'b1, 1'b0, 32'd10, "fail_stat");
    st(0, 64'h1, 8'hFF);
    stat(1'b1, 1'b0, 32'd10, "fail_sticky");
    st(4, 64'd5, 8'hFF);
    ld(BASE + 64'd32, 64'd0, "wdl_ignored_in_done");

    // Console FIFO
    do_reset_async("con");
    con_ready = 1'b0;
    st(3, 64'h48, 8'h01);
    st(3, 64'h69, 8'h01);
    ld(BASE + 64'd24, 64'd0, "con_status_2");
    st(3, 64'h21, 8'h01);
    st(3, 64'h3F, 8'h01);
    ld(BASE + 64'd24, 64'd1, "con_status_full");
    st(3, 64'h58, 8'h01);
    ld(BASE + 64'd24, 64'd3, "con_status_ovf");
    ld(BASE + 64'd25, 64'd0, "misaligned_read");
    ld(BASE + 64'd40, 64'd0, "reserved5_read");
    ld(BASE + 64'd56, 64'd0, "reserved7_read");
    ld(BASE,          64'd0, "tohost_read");
    // Push while full with a simultaneous pop
    exp_con(8'h48, "con_H");
    con_ready = 1'b1;
    st(3, 64'h5A, 8'h01);
    con_ready = 1'b0;
    ld(BASE + 64'd24, 64'd3, "con_status_pushpop");
    exp_con(8'h69, "con_i");
    exp_con(8'h21, "con_bang");
    exp_con(8'h3F, "con_q");
    exp_con(8'h5A, "con_Z");
    con_ready = 1'b1;
    repeat (4) tick();
    check("con_drained", {63'd0, con_valid}, 64'd0);
    ld(BASE + 64'd24, 64'd2, "con_status_sticky_ovf");
    con_ready = 1'b0;

    // Watchdog fires
    do_reset_async("wd");
    st(4, 64'hAABB_CCDD, 8'h0F);
    ld(BASE + 64'd32, 64'hAABB_CCDD, "wdl_full_write");
    st(4, 64'h0, 8'h0E);
    ld(BASE + 64'd32, 64'h0000_00DD, "wdl_masked_write");
    st(4, 64'hFFFF_FFFF_0000_0064, 8'hFF);
    ld(BASE + 64'd32, 64'd100, "wdl_100");
    repeat (98) tick();
    stat(1'b0, 1'b0, 32'd0, "wd_not_yet");
    stat(1'b1, 1'b0, 32'hFFFF_FFFF, "wd_fired");

    // Watchdog kept alive by retire
    do_reset_async("wdr");
    st(4, 64'd100, 8'h0F);
    for (int k = 0; k < 6; k++) begin
      repeat (49) tick();
      retire = 1'b1;
      tick();
      retire = 1'b0;
    end
    stat(1'b0, 1'b0, 32'd0, "wd_kept_alive");

    // INSTRET
    do_reset_async("ir");
    for (int k = 0; k < 37; k++) begin
      retire = 1'b1;
      tick();
      retire = 1'b0;
      tick();
    end
    st(0, 64'h1, 8'h01);
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
`ifdef SIM_CTRL_INSTRET_EN
    ld(BASE + 64'd16, 64'd37, "instret_37");
`else
    ld(BASE + 64'd16, 64'd0, "instret_absent");
`endif
    stat(1'b1, 1'b1, 32'd0, "ir_pass_stat");

    tick();
    if (rd_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL rd_leftover: got %0d pending expected 0", rd_q.size());
    end
    if (con_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL con_leftover: got %0d pending expected 0", con_q.size());
    end
    if (st_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL stat_leftover: got %0d pending expected 0", st_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_ctrl_dev.md
Name: sim_ctrl_dev

Overview:
- Memory-mapped simulation-control peripheral sitting directly downstream of the core's MEM stage, beside data memory; decodes loads/stores aimed at a small MMIO window.
- Lets test software report pass/fail (tohost), emit console bytes through a small FIFO, and read cycle/retire counters.
- Also runs a hang watchdog, so benches end on a single `done` flag instead of probing register-file internals.

Parameters:
- BASE_ADDR, 64'h0000_0000_1000_0000, byte address of the MMIO window (window is 64 bytes, 8 doublewords).
- FIFO_DEPTH, 4, console FIFO entries; power of two, at least 2.
- WD_RESET, 32'd0, watchdog limit at reset; 0 = disabled.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- mem_we  in  1  store valid this cycle (MEM stage)
- mem_re  in  1  load valid this cycle (MEM stage)
- mem_addr  in  64  byte address
- mem_wdata  in  64  store data
- mem_be  in  8  byte enables for the store
- retire  in  1  one instruction retired this cycle (WB stage)
- hit  out  1  mem_addr lies in the window; MEM stage selects rdata over data memory
- rdata  out  64  load data, combinational, valid while hit && mem_re
- con_valid  out  1  console byte available
- con_data  out  8  console byte
- con_ready  in  1  consumer accepts the byte
- done  out  1  test finished, sticky
- pass  out  1  done with exit code 0
- exit_code  out  32  final code

Behaviour:
- Reset (async, rst=1): all counters 0; FIFO empty; con_valid=0; done=0, pass=0, exit_code=0; wd_limit=WD_RESET; state=RUN.
- Decode: hit = (mem_addr[63:6] == BASE_ADDR[63:6]); register index = mem_addr[5:3]. Accesses with mem_addr[2:0] != 0 are ignored and read 0.
- Register map:
  - 0 TOHOST (W): store with mem_be[0] set and wdata[0]=1 → next edge done=1, exit_code=wdata[32:1], pass=(wdata[32:1]==0). wdata[0]=0 is ignored. Reads 0.
  - 1 CYCLE (R): 64-bit, increments every cycle in RUN.
  - 2 INSTRET (R): see optional feature.
  - 3 CONSOLE (W): mem_be[0] set → push wdata[7:0]. Reads {62'b0, overflow, full}.
  - 4 WD_LIMIT (R/W): bits [31:0], byte-enable masked write; a write also clears the watchdog counter.
  - 5–7: reserved; read 0, writes ignored.
- All writes take effect at the next rising clk; reads reflect pre-edge state.
- State machine:
  - RUN → DONE on a valid TOHOST write, or when the watchdog fires.
  - DONE is left only by rst.
  - In DONE: CYCLE, INSTRET and watchdog freeze; TOHOST and WD_LIMIT writes are ignored; console pushes and drains continue.
- Watchdog:
  - wd_cnt clears on retire, otherwise increments, only when wd_limit != 0 and in RUN.
  - When wd_cnt == wd_limit-1 and retire=0: done=1, pass=0, exit_code=32'hFFFF_FFFF.
  - A TOHOST write in the same cycle takes priority over the watchdog.
- Console FIFO:
  - Standard ready/valid: con_valid=!empty; con_data=head entry, registered.
  - Pop when con_valid && con_ready.
  - Push when full is dropped and sets sticky overflow, which clears only on rst.
  - Simultaneous push and pop while full is accepted (count unchanged).
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Counters wrap modulo 2^64 silently.

Optional Feature:
- Macro SIM_CTRL_INSTRET_EN.
- Defined: a 64-bit INSTRET counter increments on retire while in RUN, frozen in DONE, and is readable at index 2.
- Undefined: no counter is built; index 2 reads 0; retire still feeds the watchdog.

Test Plan:
- Reset mid-operation: load FIFO with 2 bytes, set done via TOHOST, assert rst asynchronously between edges → all outputs 0 immediately; con_valid=0; CYCLE restarts at 0.
- Pass: after 20 cycles store 64'h1 to BASE_ADDR → done=1, pass=1, exit_code=0 one edge later; CYCLE reads 20–21 and stays frozen.
- Fail: store 64'h15 to TOHOST → exit_code=10, pass=0; a later store of 64'h1 → exit_code stays 10.
- Console: con_ready=0, push 'H','i','!','?','X' (FIFO_DEPTH=4) → 'X' dropped, status reads 3 (overflow|full); raise con_ready → bytes emerge in order H,i,!,? one per cycle, then con_valid=0.
- Watchdog: write WD_LIMIT=100, hold retire=0 → done on the 100th cycle after the write, exit_code=FFFF_FFFF. Retire pulses every 50 cycles → never fires.
- INSTRET with macro defined: 37 retire pulses then TOHOST=1 → index 2 reads 37. Macro undefined → reads 0.
